// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM memory responder.
package avalon_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] ERR_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] data;
  } rd_slot_t;

  // Any address bit above the word-index field marks the access as out of range.
  function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned addr_w);
    return (addr >> (addr_w + 2)) != 32'd0;
  endfunction

endpackage

// File: rtl/avalon_read_delay_line.sv
// Fixed-latency shift register carrying read returns from acceptance to readdatavalid.
module avalon_read_delay_line
  import avalon_pkg::*;
#(
  parameter int unsigned LATENCY = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rd_slot_t in_slot,
  output rd_slot_t out_slot
);

  rd_slot_t slot_q [LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q[0] <= in_slot;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        slot_q[i] <= slot_q[i-1];
      end
    end
  end

  assign out_slot = slot_q[LATENCY-1];

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave backed by a word memory, with fixed read latency, a pending-read cap and
// periodic waitrequest insertion for exercising masters under backpressure.
module avalon_mem_responder
  import avalon_pkg::*;
#(
  parameter int unsigned ADDR_W       = 10,
  parameter int unsigned READ_LATENCY = 3,
  parameter int unsigned MAX_PENDING  = 4,
  parameter int unsigned WAIT_EVERY   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       slave_address,
  input  logic              slave_read,
  input  logic              slave_write,
  input  logic [WORD_W-1:0] slave_writedata,
  output logic              slave_waitrequest,
  output logic [WORD_W-1:0] slave_readdata,
  output logic              slave_readdatavalid,
  output logic [31:0]       read_count,
  output logic [31:0]       write_count,
  output logic              err
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned PEND_W = $clog2(MAX_PENDING + 1);
  localparam int unsigned ACC_W  = (WAIT_EVERY > 1) ? $clog2(WAIT_EVERY) : 1;

  logic [WORD_W-1:0] mem_q [DEPTH];

  logic [PEND_W-1:0] pending_q, pending_d;
  logic [ACC_W-1:0]  accept_cnt_q, accept_cnt_d;
  logic              stall_q, stall_d;
  logic [31:0]       read_count_q, read_count_d;
  logic [31:0]       write_count_q, write_count_d;
  logic              err_q, err_d;

  logic              accept, do_write, do_read, oob;
  logic [ADDR_W-1:0] word_idx;
  rd_slot_t          rd_in, rd_out;

  // Decoded from registers only, so masters never see a combinational loop through us.
  assign slave_waitrequest = stall_q | (pending_q >= PEND_W'(MAX_PENDING));

  assign accept   = (slave_read | slave_write) & ~slave_waitrequest;
  assign do_write = accept & slave_write;
  assign do_read  = accept & slave_read & ~slave_write;
  assign word_idx = slave_address[ADDR_W+1:2];
  assign oob      = addr_out_of_range(slave_address, ADDR_W);

  always_comb begin
    rd_in.valid = do_read;
    rd_in.data  = '0;
    if (do_read) begin
      rd_in.data = oob ? ERR_DATA : mem_q[word_idx];
    end
  end

  avalon_read_delay_line #(
    .LATENCY (READ_LATENCY)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_slot  (rd_in),
    .out_slot (rd_out)
  );

  always_comb begin
    pending_d     = pending_q;
    accept_cnt_d  = accept_cnt_q;
    stall_d       = 1'b0;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    err_d         = err_q;

    unique case ({do_read, rd_out.valid})
      2'b10:   pending_d = pending_q + 1'b1;
      2'b01:   pending_d = pending_q - 1'b1;
      default: pending_d = pending_q;
    endcase

    if (do_write) begin
      write_count_d = write_count_q + 32'd1;
    end
    if (do_read) begin
      read_count_d = read_count_q + 32'd1;
    end
    if (accept && (oob || (slave_read && slave_write))) begin
      err_d = 1'b1;
    end

    // The accept that wraps the counter buys exactly one waitrequest cycle.
    if ((WAIT_EVERY != 0) && accept) begin
      if (32'(accept_cnt_q) == WAIT_EVERY - 1) begin
        accept_cnt_d = '0;
        stall_d      = 1'b1;
      end else begin
        accept_cnt_d = accept_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q     <= '0;
      accept_cnt_q  <= '0;
      stall_q       <= 1'b0;
      read_count_q  <= '0;
      write_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      accept_cnt_q  <= accept_cnt_d;
      stall_q       <= stall_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      err_q         <= err_d;
    end
  end

  // Contents survive reset; out-of-range writes are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (rst_n && do_write && !oob) begin
      mem_q[word_idx] <= slave_writedata;
    end
  end

  assign slave_readdatavalid = rd_out.valid;
  assign slave_readdata      = rd_out.data;
  assign read_count          = read_count_q;
  assign write_count         = write_count_q;
  assign err                 = err_q;

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Bench for avalon_mem_responder: model-checked default instance plus directed
// backpressure scenarios on stall and pending-cap variants.
module tb_avalon_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [31:0] m_addr, m_wdata, m_rdata, m_rcnt, m_wcnt;
  logic        m_rd, m_wr, m_wait, m_valid, m_err;
  logic [31:0] w_addr, w_wdata, w_rdata, w_rcnt, w_wcnt;
  logic        w_rd, w_wr, w_wait, w_valid, w_err;
  logic [31:0] p_addr, p_wdata, p_rdata, p_rcnt, p_wcnt;
  logic        p_rd, p_wr, p_wait, p_valid, p_err;

  avalon_mem_responder u_dut (
    .clk(clk), .rst_n(rst_n), .slave_address(m_addr), .slave_read(m_rd), .slave_write(m_wr),
    .slave_writedata(m_wdata), .slave_waitrequest(m_wait), .slave_readdata(m_rdata),
    .slave_readdatavalid(m_valid), .read_count(m_rcnt), .write_count(m_wcnt), .err(m_err)
  );

  avalon_mem_responder #(.WAIT_EVERY(2)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .slave_address(w_addr), .slave_read(w_rd), .slave_write(w_wr),
    .slave_writedata(w_wdata), .slave_waitrequest(w_wait), .slave_readdata(w_rdata),
    .slave_readdatavalid(w_valid), .read_count(w_rcnt), .write_count(w_wcnt), .err(w_err)
  );

  avalon_mem_responder #(.READ_LATENCY(4), .MAX_PENDING(2)) u_dut_p (
    .clk(clk), .rst_n(rst_n), .slave_address(p_addr), .slave_read(p_rd), .slave_write(p_wr),
    .slave_writedata(p_wdata), .slave_waitrequest(p_wait), .slave_readdata(p_rdata),
    .slave_readdatavalid(p_valid), .read_count(p_rcnt), .write_count(p_wcnt), .err(p_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model of the default instance: latency 3, at most 4 reads in flight.
  localparam int M_LAT = 3;
  localparam int M_PEND = 4;
  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;
  exp_t        q[$];
  logic [31:0] mem_m [1024];
  int          cyc = 0;
  logic [31:0] rc_m = 0, wc_m = 0;
  logic        err_m = 1'b0;

  task automatic step(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd);
    logic        ev;
    logic [31:0] ed;
    int          pend;
    logic        acc, oob;
    exp_t        e;
    m_rd = rd; m_wr = wr; m_addr = addr; m_wdata = wd;
    @(negedge clk);
    ev = 1'b0;
    if (q.size() > 0) ev = (q[0].due == cyc);
    ed = ev ? q[0].data : 32'h0;
    pend = q.size();
    chk($sformatf("m_valid_c%0d", cyc), m_valid, ev);
    chk($sformatf("m_rdata_c%0d", cyc), m_rdata, ed);
    chk($sformatf("m_wait_c%0d", cyc), m_wait, pend >= M_PEND);
    chk($sformatf("m_rcnt_c%0d", cyc), m_rcnt, rc_m);
    chk($sformatf("m_wcnt_c%0d", cyc), m_wcnt, wc_m);
    chk($sformatf("m_err_c%0d", cyc), m_err, err_m);
    if (!rst_n) begin
      q.delete();
      rc_m = 0; wc_m = 0; err_m = 1'b0;
    end else begin
      if (ev) void'(q.pop_front());
      acc = (rd || wr) && (pend < M_PEND);
      oob = addr[31:12] != 20'd0;
      if (acc) begin
        if (oob || (rd && wr)) err_m = 1'b1;
        if (wr) begin
          wc_m++;
          if (!oob) mem_m[addr[11:2]] = wd;
        end else begin
          rc_m++;
          e.due  = cyc + M_LAT;
          e.data = oob ? 32'hDEADBEEF : mem_m[addr[11:2]];
          q.push_back(e);
        end
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int          nacc, vidx;
    logic [31:0] a, wd;
    logic        rd, wr;
    rst_n = 1'b0;
    m_rd = 0; m_wr = 0; m_addr = 0; m_wdata = 0;
    w_rd = 0; w_wr = 0; w_addr = 0; w_wdata = 0;
    p_rd = 0; p_wr = 0; p_addr = 0; p_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single write then read: data appears exactly three cycles after acceptance.
    step(1'b0, 1'b1, 32'h10, 32'h12345678);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    idle(4);

    // Back-to-back reads return back-to-back in order.
    step(1'b0, 1'b1, 32'h0, 32'hAAAA0001);
    step(1'b0, 1'b1, 32'h4, 32'hBBBB0002);
    step(1'b0, 1'b1, 32'h8, 32'hCCCC0003);
    step(1'b0, 1'b1, 32'hC, 32'hDDDD0004);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(5);

    // Out-of-range write is dropped, out-of-range read yields the error pattern.
    step(1'b0, 1'b1, 32'h1000, 32'hCAFEF00D);
    step(1'b1, 1'b0, 32'h1000, 32'h0);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    idle(4);
    step(1'b1, 1'b1, 32'h20, 32'h55AA55AA);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    idle(4);

    // Reset with a read in flight: it never returns, memory survives.
    step(1'b1, 1'b0, 32'h10, 32'h0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    idle(10);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    idle(4);

    // Randomized traffic over a prewritten window with occasional out-of-range hits.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i * 4), $urandom);
    for (int i = 0; i < 400; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      a  = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(12, 31));
      wd = $urandom;
      step(rd, wr, a, wd);
    end
    idle(6);

    // WAIT_EVERY=2: a held write sees waitrequest in cycles 2 and 5 only.
    nacc = 0;
    for (int c = 0; c < 7; c++) begin
      w_wr = (nacc < 4); w_addr = 32'(nacc * 4); w_wdata = 32'hA0000000 + 32'(nacc);
      @(negedge clk);
      chk($sformatf("w_wait_c%0d", c), w_wait, (c == 2) || (c == 5));
      if (w_wr && !w_wait) nacc++;
      @(posedge clk);
      #1;
    end
    w_wr = 1'b0;
    chk("w_write_count", w_wcnt, 32'd4);
    chk("w_err", w_err, 1'b0);
    w_rd = 1'b1; w_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("w_rd_wait", w_wait, 1'b0);
      chk($sformatf("w_valid_k%0d", k), w_valid, k == 3);
      chk($sformatf("w_rdata_k%0d", k), w_rdata, (k == 3) ? 32'hA0000001 : 32'h0);
      @(posedge clk);
      #1;
      w_rd = 1'b0;
    end

    // READ_LATENCY=4, MAX_PENDING=2: held reads accepted at 0,1,5,6; valid at 4,5,9,10.
    for (int k = 0; k < 4; k++) begin
      p_wr = 1'b1; p_addr = 32'(k * 4); p_wdata = 32'hB0000000 + 32'(k);
      @(negedge clk);
      chk($sformatf("p_wr_wait_k%0d", k), p_wait, 1'b0);
      @(posedge clk);
      #1;
    end
    p_wr = 1'b0;
    nacc = 0; vidx = 0;
    for (int c = 0; c < 12; c++) begin
      p_rd = (nacc < 4); p_addr = 32'(nacc * 4);
      @(negedge clk);
      chk($sformatf("p_wait_c%0d", c), p_wait, (c >= 2 && c <= 4) || (c >= 7 && c <= 9));
      chk($sformatf("p_valid_c%0d", c), p_valid, (c == 4) || (c == 5) || (c == 9) || (c == 10));
      if (p_valid) begin
        chk($sformatf("p_rdata_c%0d", c), p_rdata, 32'hB0000000 + 32'(vidx));
        vidx++;
      end
      if (p_rd && !p_wait) nacc++;
      @(posedge clk);
      #1;
    end
    p_rd = 1'b0;
    chk("p_read_count", p_rcnt, 32'd4);
    chk("p_write_count", p_wcnt, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avalon_mem_responder.md
Name: avalon_mem_responder

Overview:
Avalon-MM slave responder backed by an on-chip word memory; it answers an Avalon-MM master such as the SDRAM-facing port of the word-copy DMA.
- Fixed, parameterised read latency, with reads pipelined and returned in order.
- Deterministic waitrequest insertion and an outstanding-read cap, so masters can be exercised under backpressure.
- Used as an SDRAM stand-in in simulation and as a small scratchpad in synthesis.

Parameters:
- ADDR_W, 10: word-address bits; memory depth is 2^ADDR_W 32-bit words.
- READ_LATENCY, 3: cycles from read acceptance to readdatavalid; legal range is 1 or more.
- MAX_PENDING, 4: maximum accepted reads not yet returned; legal range is 1 or more.
- WAIT_EVERY, 0: if greater than 0, force one waitrequest cycle after every WAIT_EVERY accepted commands; 0 disables this.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- slave_address  in  32  byte address
- slave_read  in  1  read request
- slave_write  in  1  write request
- slave_writedata  in  32  write data
- slave_waitrequest  out  1  command not accepted this cycle
- slave_readdata  out  32  read data; 0 when readdatavalid=0
- slave_readdatavalid  out  1  readdata valid, one pulse per accepted read
- read_count  out  32  accepted reads, wraps at 2^32
- write_count  out  32  accepted writes, wraps at 2^32
- err  out  1  sticky protocol/address error flag

Behaviour:
- Reset (clk edge with rst_n=0):
  - readdatavalid=0, readdata=0, read_count=0, write_count=0, err=0.
  - Delay line, pending_cnt, stall flag and accept counter are cleared.
  - Memory contents are not reset.
  - In-flight reads are discarded and never return.
  - waitrequest=0 in the first cycle after reset.
- waitrequest = stall_flag OR (pending_cnt >= MAX_PENDING). It is decoded from registers only; there is no combinational path from the inputs.
- Acceptance: accept = (slave_read OR slave_write) AND NOT slave_waitrequest.
  - The master holds its request through waitrequest.
  - read and write both high: treated as a write only, and err is set.
- Addressing:
  - Word index = slave_address[ADDR_W+1:2]; bits [1:0] are ignored.
  - Out of range means slave_address[31:ADDR_W+2] != 0. An out-of-range write is dropped (no aliasing). An out-of-range read returns ERR_DATA=32'hDEADBEEF. Both set err and still count as accepted.
- Write: memory is updated at the accepting edge; write_count increments.
- Read:
  - At the accepting edge, mem[idx] (or ERR_DATA) enters the delay line.
  - A read accepted in cycle t gives readdatavalid=1 with that data in cycle t+READ_LATENCY.
  - The read sees every write accepted before cycle t.
  - read_count increments at acceptance.
  - Returns are strictly in order; back-to-back accepts give back-to-back valids.
- pending_cnt: +1 on read accept, -1 in any cycle with readdatavalid=1. Both in the same cycle leaves it unchanged.
  - Full is judged on the registered value, so a slot freed in cycle t is usable in t+1.
- Stall:
  - accept_cnt counts all accepts modulo WAIT_EVERY.
  - When an accept makes accept_cnt wrap to 0, stall_flag=1 for exactly the next cycle, then clears.
  - With WAIT_EVERY=0, stall_flag stays 0.
- err is sticky until reset.

Decomposition:
- Package avalon_pkg:
  - WORD_W=32, ERR_DATA=32'hDEADBEEF.
  - typedef rd_slot_t {logic valid; logic [31:0] data;}.
- Sub-module avalon_read_delay_line: a READ_LATENCY-deep shift register of rd_slot_t, with synchronous clear on reset; its output drives readdatavalid/readdata.
- Top level: memory array, address check, acceptance logic, pending_cnt, stall logic, counters.

Test Plan:
1. Defaults. Write 32'h12345678 to 0x10, then read 0x10 accepted at cycle t -> readdatavalid only at t+3 with 32'h12345678; write_count=1, read_count=1, err=0.
2. Defaults. Write words A..D to 0x0..0xC, then 4 back-to-back reads with no waitrequest -> 4 consecutive valid cycles returning A,B,C,D in order.
3. WAIT_EVERY=2. Hold slave_write for 4 writes starting at cycle 0 -> accepts at cycles 0,1,3,4; waitrequest=1 only in cycles 2 and 5; write_count=4.
4. READ_LATENCY=4, MAX_PENDING=2. Hold slave_read -> accepts at cycles 0,1,5,6; valids at cycles 4,5,9,10.
5. ADDR_W=10:
   - Write 32'hCAFEF00D to 0x1000, then read 0x1000 -> readdata 32'hDEADBEEF and err=1.
   - Read 0x0 -> returns its prior value, unchanged by the dropped write.
   - Assert read and write together -> treated as a write and err=1.
6. Read accepted at cycle t; rst_n=0 at t+1 -> no readdatavalid through t+10; all counters 0; a later read of the same address returns the pre-reset memory data.
